// File: rtl/tdc_capture_pkg.sv
// Shared types and constants for the tdc_capture time-to-digital front end.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HDR   = 2'd2,
    DATA  = 2'd3
  } tdc_state_e;

  localparam logic [7:0] HEADER_DEF     = 8'hA5;
  localparam logic [7:0] HEADER_OVF_DEF = 8'h5A;

  // Width of the byte index for a cnt_w-bit result; never narrower than 1 bit.
  function automatic int idx_width(input int cnt_w);
    int nb;
    nb = cnt_w / 8;
    return (nb <= 1) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/tdc_capture_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector; all flops reset high.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting to 1 means an input already high at reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tdc_capture.sv
// Measures start-to-stop interval in clk cycles and streams {header, result MSB..LSB}
// over a valid/ready byte interface.
module tdc_capture
  import tdc_pkg::*;
#(
  parameter int         CNT_W       = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter logic [7:0] HEADER_OVF  = HEADER_OVF_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       axi_ready,
  output logic       axi_valid,
  output logic [7:0] axi_data,
  output logic       busy
);

  // Handshake: a byte moves on a clk edge with axi_valid && axi_ready; valid is a
  // register that never looks at ready, and valid/data hold until that edge.

  localparam int NB    = CNT_W / 8;
  localparam int IDX_W = idx_width(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NB - 1);

  tdc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] result_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic [7:0]       data_q;

  logic             start_rise;
  logic             stop_rise;
  logic [CNT_W-1:0] cnt_inc_d;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_edge (
    .clk     (clk),
    .rst     (rst),
    .d_async (start),
    .rise    (start_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop_edge (
    .clk     (clk),
    .rst     (rst),
    .d_async (stop),
    .rise    (stop_rise)
  );

  assign cnt_inc_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  function automatic logic [7:0] byte_at(input logic [CNT_W-1:0] v,
                                         input logic [IDX_W-1:0] i);
    logic [CNT_W-1:0] s;
    s = v >> (int'(i) * 8);
    return s[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A simultaneous stop edge is dropped here simply by not being looked at.
          if (start_rise) begin
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          cnt_q <= cnt_inc_d;
          if (stop_rise) begin
            result_q <= cnt_inc_d;
            valid_q  <= 1'b1;
            data_q   <= (cnt_inc_d == CNT_MAX) ? HEADER_OVF : HEADER;
            state_q  <= HDR;
          end
        end
        HDR: begin
          if (axi_ready) begin
            data_q  <= byte_at(result_q, IDX_TOP);
            idx_q   <= IDX_TOP;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (axi_ready) begin
            if (idx_q == '0) begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_q - 1'b1;
              data_q <= byte_at(result_q, idx_q - 1'b1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axi_valid = valid_q;
  assign axi_data  = data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_capture.sv
// Bench for tdc_capture: directed scenarios plus randomized intervals and ready patterns,
// each frame checked against a frame computed from the measured interval.
module tb_tdc_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic       stop = 1'b0;
  logic       axi_ready = 1'b0;
  logic       axi_valid;
  logic [7:0] axi_data;
  logic       busy;

  logic       start8 = 1'b0;
  logic       stop8 = 1'b0;
  logic       ready8 = 1'b1;
  logic       valid8;
  logic [7:0] data8;
  logic       busy8;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got8_q[$];
  int         got_cyc_q[$];
  logic       got_busy_q[$];

  logic       stall_seen = 1'b0;
  logic [7:0] stall_data = '0;

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tdc_capture #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .axi_ready (axi_ready),
    .axi_valid (axi_valid),
    .axi_data  (axi_data),
    .busy      (busy)
  );

  tdc_capture #(.CNT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .stop      (stop8),
    .axi_ready (ready8),
    .axi_valid (valid8),
    .axi_data  (data8),
    .busy      (busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: collects transferred bytes and checks hold-while-stalled.
  always @(negedge clk) begin
    if (stall_seen && !rst) begin
      check("hold_valid", {31'd0, axi_valid}, 32'd1);
      check("hold_data", {24'd0, axi_data}, {24'd0, stall_data});
    end
    stall_seen = axi_valid && !axi_ready && !rst;
    stall_data = axi_data;
    if (axi_valid && axi_ready) begin
      got_q.push_back(axi_data);
      got_cyc_q.push_back(cyc);
      got_busy_q.push_back(busy);
    end
    if (valid8 && ready8) got8_q.push_back(data8);
  end

  // Reference model: a frame is a header then the saturated count MSB first.
  task automatic model(input int n, input int cw);
    longint maxv;
    longint v;
    exp_q.delete();
    maxv = (longint'(1) << cw) - 1;
    v = (n > maxv) ? maxv : longint'(n);
    exp_q.push_back((n >= maxv) ? 8'h5A : 8'hA5);
    for (int b = cw / 8 - 1; b >= 0; b--) exp_q.push_back(8'((v >> (8 * b)) & 255));
  endtask

  // Driver tasks (inputs change 1 time unit after the rising edge)
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic measure(input int n);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(n - 1);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
  endtask

  task automatic wait_frame(input int k, input int budget, input bit use8, input bit rnd_ready);
    int t;
    t = 0;
    while (((use8 ? got8_q.size() : got_q.size()) < k) && t < budget) begin
      cycles(1);
      if (rnd_ready) axi_ready = 1'($urandom_range(0, 1));
      t++;
    end
    axi_ready = 1'b1;
  endtask

  task automatic compare_frame(input string tag, input bit use8);
    int sz;
    logic [7:0] b;
    sz = use8 ? got8_q.size() : got_q.size();
    check($sformatf("%s_len", tag), sz, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sz; i++) begin
      b = use8 ? got8_q[i] : got_q[i];
      check($sformatf("%s_byte%0d", tag, i), {24'd0, b}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic clear_got();
    got_q.delete();
    got8_q.delete();
    got_cyc_q.delete();
    got_busy_q.delete();
  endtask

  initial begin
    int n;

    // Reset with start already high: no edge, no frame.
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, axi_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, axi_data}, 32'd0);
    check("rst_valid8", {31'd0, valid8}, 32'd0);
    cycles(1);
    rst = 1'b0;
    axi_ready = 1'b1;
    cycles(20);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_valid", {31'd0, axi_valid}, 32'd0);
    start = 1'b0;
    cycles(5);
    check("post_rst_frames", got_q.size(), 32'd0);

    // Basic N=100 with ready held high.
    model(100, 16);
    measure(100);
    wait_frame(3, 200, 1'b0, 1'b0);
    compare_frame("basic", 1'b0);
    if (got_q.size() == 3) begin
      check("basic_back_to_back", got_cyc_q[2] - got_cyc_q[0], 32'd2);
      check("basic_busy_last", {31'd0, got_busy_q[2]}, 32'd1);
    end
    @(negedge clk);
    check("basic_busy_after", {31'd0, busy}, 32'd0);
    check("basic_valid_after", {31'd0, axi_valid}, 32'd0);
    cycles(2);
    clear_got();

    // Smallest interval.
    model(1, 16);
    measure(1);
    wait_frame(3, 200, 1'b0, 1'b0);
    compare_frame("n1", 1'b0);
    cycles(3);
    clear_got();

    // Backpressure on the MSB byte.
    axi_ready = 1'b0;
    model(16'h1234, 16);
    measure(16'h1234);
    for (int t = 0; t < 50 && !axi_valid; t++) cycles(1);
    check("bp_hdr_valid", {31'd0, axi_valid}, 32'd1);
    check("bp_hdr_data", {24'd0, axi_data}, 32'hA5);
    axi_ready = 1'b1;
    cycles(1);
    axi_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("bp_msb_valid", {31'd0, axi_valid}, 32'd1);
      check("bp_msb_data", {24'd0, axi_data}, 32'h12);
      cycles(1);
    end
    axi_ready = 1'b1;
    wait_frame(3, 200, 1'b0, 1'b0);
    compare_frame("bp", 1'b0);
    cycles(3);
    clear_got();

    // Saturation on the 8-bit instance.
    model(300, 8);
    start8 = 1'b1;
    cycles(1);
    start8 = 1'b0;
    cycles(299);
    stop8 = 1'b1;
    cycles(1);
    stop8 = 1'b0;
    wait_frame(2, 200, 1'b1, 1'b0);
    compare_frame("ovf8", 1'b1);
    cycles(3);
    clear_got();

    // Start+stop together, then a start retrigger that must be ignored.
    model(10, 16);
    start = 1'b1;
    stop  = 1'b1;
    cycles(1);
    start = 1'b0;
    stop  = 1'b0;
    cycles(3);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(5);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    wait_frame(3, 200, 1'b0, 1'b0);
    compare_frame("simul", 1'b0);
    cycles(3);
    clear_got();

    // Reset after the header has been accepted.
    measure(50);
    wait_frame(1, 200, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, axi_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    cycles(1);
    rst = 1'b0;
    cycles(3);
    clear_got();
    model(7, 16);
    measure(7);
    wait_frame(3, 200, 1'b0, 1'b0);
    compare_frame("after_rst", 1'b0);
    cycles(3);
    clear_got();

    // Random intervals with random downstream readiness.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3000);
      model(n, 16);
      measure(n);
      wait_frame(3, 400, 1'b0, 1'b1);
      compare_frame($sformatf("rnd%0d", r), 1'b0);
      cycles(3);
      clear_got();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
